// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle MIPS-style datapath.
// The state register and the sticky illegal flag are the only flops. All
// strobes and selects are decoded from the current state, the IR fields and
// the memory handshake, so each strobe appears in the same cycle as its state.
// Optional feature: define ILLEGAL_TRAP_EN to send undecoded instructions to
// a TRAP state that raises a sticky illegal flag. When it is undefined, such
// instructions act as NOPs.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       reg_we,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic       ext_sel,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB       = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_TRAP     = 4'd10
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_e state_q, state_d;

    // Instruction classes decoded from the IR fields.
    logic is_rtype, is_r_alu, is_jr, is_itype, is_lw, is_mem, is_bne, is_j, is_jal;
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_r_alu = is_rtype && (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_itype = (opcode == OP_ADDI) || (opcode == OP_XORI);
    assign is_lw    = (opcode == OP_LW);
    assign is_mem   = is_lw || (opcode == OP_SW);
    assign is_bne   = (opcode == OP_BNE);
    assign is_j     = (opcode == OP_J);
    assign is_jal   = (opcode == OP_JAL);

    // The extender mode depends only on the opcode, whatever the state.
    assign ext_sel = (opcode == OP_XORI);
    assign state   = state_q;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Next-state logic: memory states wait on mem_ready, all others ignore it.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_r_alu)                  state_d = S_EXEC_R;
                else if (is_jr || is_j || is_jal) state_d = S_JUMP;
                else if (is_itype)             state_d = S_EXEC_I;
                else if (is_mem)               state_d = S_MEM_ADDR;
                else if (is_bne)               state_d = S_BRANCH;
                else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
`else
                    state_d   = S_FETCH;
`endif
                end
            end
            S_EXEC_R:   state_d = S_WB;
            S_EXEC_I:   state_d = S_WB;
            S_MEM_ADDR: state_d = is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // State and sticky flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_n) begin
            state_q <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Output decode; while reset is held the outputs show a clean FETCH.
    always_comb begin
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        alu_op    = 3'b000;
        alu_src_b = 2'b00;
        reg_dst   = 2'b00;
        wb_sel    = 2'b00;
        pc_src    = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_re = 1'b1;
                ir_we  = mem_ready;
                pc_we  = mem_ready;
            end
            S_EXEC_R: begin
                case (funct)
                    FN_SUB:  alu_op = 3'b001;
                    FN_SLT:  alu_op = 3'b011;
                    default: alu_op = 3'b000;
                endcase
            end
            S_EXEC_I: begin
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_XORI) ? 3'b010 : 3'b000;
            end
            S_MEM_ADDR: alu_src_b = 2'b10;
            S_MEM_RD:   mem_re    = 1'b1;
            S_MEM_WR:   mem_we    = 1'b1;
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = is_rtype ? 2'b01 : 2'b00;
                wb_sel  = is_lw ? 2'b01 : 2'b00;
            end
            S_BRANCH: begin
                alu_op = 3'b001;
                pc_src = 2'b01;
                pc_we  = ~zero;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = is_jr ? 2'b11 : 2'b10;
                if (is_jal) begin
                    reg_we  = 1'b1;
                    reg_dst = 2'b10;
                    wb_sel  = 2'b10;
                end
            end
            default: ;
        endcase
        if (!reset_n) begin
            pc_we     = 1'b0;
            ir_we     = 1'b0;
            mem_re    = 1'b1;
            mem_we    = 1'b0;
            reg_we    = 1'b0;
            alu_op    = 3'b000;
            alu_src_b = 2'b00;
            reg_dst   = 2'b00;
            wb_sel    = 2'b00;
            pc_src    = 2'b00;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl. The driver pushes
// the expected output vector of every cycle; the monitor pops and compares it
// on the falling edge. Compile with ILLEGAL_TRAP_EN to match a trap build.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_we, ir_we, mem_re, mem_we, reg_we, ext_sel, illegal;
    logic [2:0] alu_op;
    logic [1:0] alu_src_b, reg_dst, wb_sel, pc_src;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_we, ir_we, mem_re, mem_we, reg_we;
        logic [2:0] alu_op;
        logic [1:0] src_b;
        logic       ext;
        logic [1:0] dst, wb, pcs;
        logic       ill;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    obs_t  act;
    int    n_checks = 0;
    int    n_errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we),
        .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .ext_sel(ext_sel), .reg_dst(reg_dst),
        .wb_sel(wb_sel), .pc_src(pc_src), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign act = '{state, pc_we, ir_we, mem_re, mem_we, reg_we, alu_op,
                   alu_src_b, ext_sel, reg_dst, wb_sel, pc_src, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: compare each cycle's outputs against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'(act), 32'(e));
        end
    end

    function automatic obs_t blank(input logic [3:0] st);
        obs_t e;
        e     = '0;
        e.st  = st;
        e.ext = (opcode == 6'h0E);
        return e;
    endfunction

    task automatic push_cycle(input obs_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // Hold reset across two edges; only the second cycle has a known state.
    task automatic do_reset();
        obs_t e;
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        e        = blank(4'd0);
        e.mem_re = 1'b1;
        push_cycle(e, "reset");
        reset_n = 1'b1;
    endtask

    // Drive one instruction and push the expected output of every cycle.
    // fw: FETCH wait cycles, mw: memory wait cycles, abort: reset in MEM_WR.
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw, input bit abort, input string tag);
        obs_t e;
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int i = 0; i < fw; i++) begin
            mem_ready = 1'b0;
            e = blank(4'd0); e.mem_re = 1'b1;
            push_cycle(e, {tag, "_fetch_wait"});
        end
        mem_ready = 1'b1;
        e = blank(4'd0); e.mem_re = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
        push_cycle(e, {tag, "_fetch"});
        mem_ready = 1'($urandom_range(0, 1));
        push_cycle(blank(4'd1), {tag, "_decode"});
        mem_ready = 1'($urandom_range(0, 1));
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
            e = blank(4'd2);
            e.alu_op = (fn == 6'h22) ? 3'b001 : (fn == 6'h2A) ? 3'b011 : 3'b000;
            push_cycle(e, {tag, "_exec_r"});
            e = blank(4'd7); e.reg_we = 1'b1; e.dst = 2'b01;
            push_cycle(e, {tag, "_wb"});
        end else if (op == 6'h00 && fn == 6'h08) begin
            e = blank(4'd9); e.pc_we = 1'b1; e.pcs = 2'b11;
            push_cycle(e, {tag, "_jump"});
        end else if (op == 6'h08 || op == 6'h0E) begin
            e = blank(4'd3); e.src_b = 2'b10;
            e.alu_op = (op == 6'h0E) ? 3'b010 : 3'b000;
            push_cycle(e, {tag, "_exec_i"});
            e = blank(4'd7); e.reg_we = 1'b1;
            push_cycle(e, {tag, "_wb"});
        end else if (op == 6'h23 || op == 6'h2B) begin
            e = blank(4'd4); e.src_b = 2'b10;
            push_cycle(e, {tag, "_addr"});
            for (int i = 0; i <= mw; i++) begin
                mem_ready = (i == mw);
                if (op == 6'h23) begin
                    e = blank(4'd5); e.mem_re = 1'b1;
                end else begin
                    e = blank(4'd6); e.mem_we = 1'b1;
                end
                if (abort && i == mw) begin
                    do_reset();
                    return;
                end
                push_cycle(e, {tag, "_mem"});
            end
            if (op == 6'h23) begin
                mem_ready = 1'($urandom_range(0, 1));
                e = blank(4'd7); e.reg_we = 1'b1; e.wb = 2'b01;
                push_cycle(e, {tag, "_wb"});
            end
        end else if (op == 6'h05) begin
            e = blank(4'd8); e.alu_op = 3'b001; e.pcs = 2'b01; e.pc_we = ~z;
            push_cycle(e, {tag, "_branch"});
        end else if (op == 6'h02 || op == 6'h03) begin
            e = blank(4'd9); e.pc_we = 1'b1; e.pcs = 2'b10;
            if (op == 6'h03) begin
                e.reg_we = 1'b1; e.dst = 2'b10; e.wb = 2'b10;
            end
            push_cycle(e, {tag, "_jump"});
        end else begin
`ifdef ILLEGAL_TRAP_EN
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'($urandom_range(0, 1));
                e = blank(4'd10); e.ill = 1'b1;
                push_cycle(e, {tag, "_trap"});
            end
            do_reset();
`endif
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        do_instr(6'h00, 6'h20, 1'b0, 1, 0, 1'b0, "add");
        do_instr(6'h00, 6'h22, 1'b1, 0, 0, 1'b0, "sub");
        do_instr(6'h00, 6'h2A, 1'b0, 2, 0, 1'b0, "slt");
        do_instr(6'h23, 6'h11, 1'b0, 0, 3, 1'b0, "lw");
        do_instr(6'h2B, 6'h00, 1'b0, 0, 1, 1'b0, "sw");
        do_instr(6'h2B, 6'h00, 1'b0, 0, 0, 1'b0, "sw_fast");
        do_instr(6'h05, 6'h00, 1'b1, 0, 0, 1'b0, "bne_taken_no");
        do_instr(6'h05, 6'h00, 1'b0, 0, 0, 1'b0, "bne_taken");
        do_instr(6'h0E, 6'h3F, 1'b0, 0, 0, 1'b0, "xori");
        do_instr(6'h08, 6'h00, 1'b0, 0, 0, 1'b0, "addi");
        do_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0, "j");
        do_instr(6'h03, 6'h00, 1'b0, 0, 0, 1'b0, "jal");
        do_instr(6'h00, 6'h08, 1'b0, 0, 0, 1'b0, "jr");
        do_instr(6'h00, 6'h01, 1'b0, 1, 0, 1'b0, "bad_funct");
        do_instr(6'h3F, 6'h00, 1'b0, 1, 0, 1'b0, "bad_op");
        do_instr(6'h2B, 6'h00, 1'b0, 1, 2, 1'b1, "sw_abort");
        do_instr(6'h00, 6'h20, 1'b0, 1, 0, 1'b0, "add_after_reset");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
